// File: rtl/rps_match_ctrl_if.sv
// Player move handshake bundle for rps_match_ctrl.
//   p1_move/p2_move : 2-bit move (01 rock, 10 paper, 11 scissors, 00 invalid)
//   p1_valid/p2_valid : move offered by the player
//   p1_ready/p2_ready : controller still waiting for that player's move
// master = player side, slave = match controller.
`timescale 1ns/1ps
interface rps_match_ctrl_if;
  logic [1:0] p1_move;
  logic       p1_valid;
  logic       p1_ready;
  logic [1:0] p2_move;
  logic       p2_valid;
  logic       p2_ready;

  modport master (
    output p1_move, p1_valid, p2_move, p2_valid,
    input  p1_ready, p2_ready
  );

  modport slave (
    input  p1_move, p1_valid, p2_move, p2_valid,
    output p1_ready, p2_ready
  );
endinterface

// File: rtl/rps_match_ctrl.sv
// Sequencer for one rock-paper-scissors match.
// Clears the score datapath, collects one move per player with a timeout,
// judges the round, issues a single matchresult update, holds a display
// phase, and ends the match on a win target or round limit.
// Ports:
//   clk, reset        : clock (rising edge), synchronous active-high reset
//   start             : begin a new match (honoured in IDLE/OVER only)
//   mv (slave)        : player move handshakes
//   round, win, lose  : counts fed back from the score datapath
//   matchresult       : 00 none, 01 draw, 10 p1 win, 11 p1 lose
//   score_clr         : one-cycle clear pulse to the score datapath
//   p1_shown,p2_shown : latched moves (00 = missing)
//   state             : current state encoding
//   game_over, winner : match end flag and winner (01 p1, 10 p2, 11 tie)
`timescale 1ns/1ps
module rps_match_ctrl #(
  parameter int unsigned WIN_TARGET  = 5,
  parameter int unsigned ROUNDS_MAX  = 9,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned SHOW_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  rps_match_ctrl_if.slave      mv,
  input  logic [3:0]           round,
  input  logic [3:0]           win,
  input  logic [3:0]           lose,
  output logic [1:0]           matchresult,
  output logic                 score_clr,
  output logic [1:0]           p1_shown,
  output logic [1:0]           p2_shown,
  output logic [2:0]           state,
  output logic                 game_over,
  output logic [1:0]           winner
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COLLECT = 3'd2,
    JUDGE   = 3'd3,
    UPDATE  = 3'd4,
    SHOW    = 3'd5,
    OVER    = 3'd6
  } state_t;

  state_t        st;
  logic          p1_lat, p2_lat;
  logic [TW-1:0] timer;
  logic [SW-1:0] show_cnt;
  logic          end_flag;
  logic [1:0]    judged;
  logic          end_cmp, end_sel;
  logic          p1_take, p2_take;

  assign state = st;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b10 && b == 2'b01) ||
           (a == 2'b01 && b == 2'b11) ||
           (a == 2'b11 && b == 2'b10);
  endfunction

  assign p1_take = mv.p1_valid & mv.p1_ready & (mv.p1_move != 2'b00);
  assign p2_take = mv.p2_valid & mv.p2_ready & (mv.p2_move != 2'b00);

  // Round verdict from p1's view; a missing move forfeits.
  always_comb begin
    judged = 2'b01;
    if (p1_lat && p2_lat) begin
      if (p1_shown == p2_shown)           judged = 2'b01;
      else if (beats(p1_shown, p2_shown)) judged = 2'b10;
      else                                judged = 2'b11;
    end else if (p1_lat) begin
      judged = 2'b10;
    end else if (p2_lat) begin
      judged = 2'b11;
    end
  end

  // The end test is sampled in the first SHOW cycle; with a single-cycle
  // SHOW the exit decision must use that same-cycle comparison directly.
  always_comb begin
    end_cmp = (32'(win) >= WIN_TARGET) || (32'(lose) >= WIN_TARGET) ||
              (32'(round) >= ROUNDS_MAX);
    end_sel = (show_cnt == '0) ? end_cmp : end_flag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      matchresult <= '0;
      score_clr   <= 1'b0;
      mv.p1_ready <= 1'b0;
      mv.p2_ready <= 1'b0;
      p1_shown    <= '0;
      p2_shown    <= '0;
      p1_lat      <= 1'b0;
      p2_lat      <= 1'b0;
      timer       <= '0;
      show_cnt    <= '0;
      end_flag    <= 1'b0;
      game_over   <= 1'b0;
      winner      <= '0;
    end else begin
      score_clr   <= 1'b0;
      matchresult <= '0;
      case (st)
        IDLE: begin
          if (start) begin
            st        <= CLEAR;
            score_clr <= 1'b1;
          end
        end
        CLEAR: begin
          p1_lat      <= 1'b0;
          p2_lat      <= 1'b0;
          p1_shown    <= '0;
          p2_shown    <= '0;
          timer       <= '0;
          mv.p1_ready <= 1'b1;
          mv.p2_ready <= 1'b1;
          st          <= COLLECT;
        end
        COLLECT: begin
          timer <= timer + 1'b1;
          if (p1_lat && p2_lat) begin
            st <= JUDGE;
          end else begin
            if (p1_take) begin
              p1_lat      <= 1'b1;
              p1_shown    <= mv.p1_move;
              mv.p1_ready <= 1'b0;
            end
            if (p2_take) begin
              p2_lat      <= 1'b1;
              p2_shown    <= mv.p2_move;
              mv.p2_ready <= 1'b0;
            end
            if (timer == TW'(TIMEOUT - 1)) begin
              st          <= JUDGE;
              mv.p1_ready <= 1'b0;
              mv.p2_ready <= 1'b0;
            end
          end
        end
        JUDGE: begin
          matchresult <= judged;
          st          <= UPDATE;
        end
        UPDATE: begin
          show_cnt <= '0;
          st       <= SHOW;
        end
        SHOW: begin
          if (show_cnt == '0) end_flag <= end_cmp;
          show_cnt <= show_cnt + 1'b1;
          if (show_cnt == SW'(SHOW_CYCLES - 1)) begin
            if (end_sel) begin
              st        <= OVER;
              game_over <= 1'b1;
              winner    <= (win > lose) ? 2'b01 : (lose > win) ? 2'b10 : 2'b11;
            end else begin
              st          <= COLLECT;
              p1_lat      <= 1'b0;
              p2_lat      <= 1'b0;
              p1_shown    <= '0;
              p2_shown    <= '0;
              timer       <= '0;
              mv.p1_ready <= 1'b1;
              mv.p2_ready <= 1'b1;
            end
          end
        end
        OVER: begin
          if (start) begin
            st        <= CLEAR;
            score_clr <= 1'b1;
            game_over <= 1'b0;
            winner    <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed bench for rps_match_ctrl with a behavioural score datapath.
`timescale 1ns/1ps
module tb_rps_match_ctrl;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] round = '0, win = '0, lose = '0;
  logic [1:0] matchresult, p1_shown, p2_shown, winner;
  logic       score_clr, game_over;
  logic [2:0] state;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  rps_match_ctrl_if mv();

  rps_match_ctrl #(
    .WIN_TARGET(5), .ROUNDS_MAX(9), .TIMEOUT(20), .SHOW_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mv(mv),
    .round(round), .win(win), .lose(lose),
    .matchresult(matchresult), .score_clr(score_clr),
    .p1_shown(p1_shown), .p2_shown(p2_shown), .state(state),
    .game_over(game_over), .winner(winner)
  );

  // Score datapath: resetn = ~score_clr, counts every non-zero matchresult.
  always @(posedge clk) begin
    if (score_clr) begin
      round <= '0; win <= '0; lose <= '0;
    end else if (matchresult != 2'b00) begin
      round <= round + 1'b1;
      if (matchresult == 2'b10) win  <= win + 1'b1;
      if (matchresult == 2'b11) lose <= lose + 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 0 of COLLECT; returns in the first cycle of the next state.
  task automatic run_round(input string tag,
                           input logic [1:0] m1, input int c1,
                           input logic [1:0] m1x, input int c1x,
                           input logic [1:0] m2, input int c2,
                           input int exp_judge, input logic [1:0] exp_mr,
                           input logic [1:0] exp_s1, input logic [1:0] exp_s2,
                           input logic [3:0] exp_round, input logic [3:0] exp_win,
                           input logic [3:0] exp_lose, input logic [2:0] exp_next);
    int edges;
    bit hit, lat1, lat2;
    edges = 0; hit = 0; lat1 = 0; lat2 = 0;
    chk({tag, "_collect"}, 32'(state), 32'(3'd2));
    for (int c = 0; c < 40 && !hit; c++) begin
      mv.p1_valid = (c == c1) || (c == c1x);
      mv.p1_move  = (c == c1x) ? m1x : m1;
      mv.p2_valid = (c == c2);
      mv.p2_move  = m2;
      tick();
      edges++;
      if (c == c1 && m1 != 2'b00) lat1 = 1;
      if (c == c2 && m2 != 2'b00) lat2 = 1;
      if (state == 3'd3) hit = 1;
      else begin
        chk({tag, "_rdy1"}, 32'(mv.p1_ready), 32'(!lat1));
        chk({tag, "_rdy2"}, 32'(mv.p2_ready), 32'(!lat2));
      end
    end
    mv.p1_valid = 1'b0;
    mv.p2_valid = 1'b0;
    chk({tag, "_judge_edges"}, 32'(edges), 32'(exp_judge));
    tick();
    chk({tag, "_upd_state"}, 32'(state), 32'(3'd4));
    chk({tag, "_mr"}, 32'(matchresult), 32'(exp_mr));
    tick();
    chk({tag, "_show_state"}, 32'(state), 32'(3'd5));
    chk({tag, "_mr_drop"}, 32'(matchresult), 32'(2'b00));
    chk({tag, "_p1_shown"}, 32'(p1_shown), 32'(exp_s1));
    chk({tag, "_p2_shown"}, 32'(p2_shown), 32'(exp_s2));
    chk({tag, "_round"}, 32'(round), 32'(exp_round));
    chk({tag, "_win"}, 32'(win), 32'(exp_win));
    chk({tag, "_lose"}, 32'(lose), 32'(exp_lose));
    for (int k = 1; k < 4; k++) begin
      tick();
      chk({tag, "_show_hold"}, 32'(state), 32'(3'd5));
    end
    tick();
    chk({tag, "_next"}, 32'(state), 32'(exp_next));
  endtask

  initial begin
    logic [1:0] wm1 [5];
    logic [1:0] wm2 [5];
    logic [1:0] dm;
    wm1 = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    wm2 = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b11};

    reset = 1'b1; start = 1'b0;
    mv.p1_valid = 1'b0; mv.p2_valid = 1'b0;
    mv.p1_move = 2'b00; mv.p2_move = 2'b00;
    tick(); tick();
    chk("rst_state", 32'(state), 32'(3'd0));
    chk("rst_mr", 32'(matchresult), 32'(2'b00));
    chk("rst_clr", 32'(score_clr), 32'(1'b0));
    chk("rst_rdy1", 32'(mv.p1_ready), 32'(1'b0));
    chk("rst_rdy2", 32'(mv.p2_ready), 32'(1'b0));
    chk("rst_go", 32'(game_over), 32'(1'b0));
    chk("rst_winner", 32'(winner), 32'(2'b00));
    reset = 1'b0;
    tick();
    chk("idle_hold", 32'(state), 32'(3'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clear_state", 32'(state), 32'(3'd1));
    chk("clear_pulse", 32'(score_clr), 32'(1'b1));
    tick();
    chk("clear_drop", 32'(score_clr), 32'(1'b0));
    chk("cnt_cleared", 32'(round), 32'(4'd0));

    // Match 1
    run_round("r1", 2'b01, 0, 2'b00, -1, 2'b11, 0, 2, 2'b10, 2'b01, 2'b11, 4'd1, 4'd1, 4'd0, 3'd2);
    run_round("r2", 2'b10, 3, 2'b11, 5, 2'b10, 7, 9, 2'b01, 2'b10, 2'b10, 4'd2, 4'd1, 4'd0, 3'd2);
    run_round("r3", 2'b01, 0, 2'b00, -1, 2'b00, -1, 20, 2'b10, 2'b01, 2'b00, 4'd3, 4'd2, 4'd0, 3'd2);
    run_round("r4", 2'b00, -1, 2'b00, -1, 2'b00, -1, 20, 2'b01, 2'b00, 2'b00, 4'd4, 4'd2, 4'd0, 3'd2);
    run_round("r5", 2'b00, 2, 2'b00, -1, 2'b11, 1, 20, 2'b11, 2'b00, 2'b11, 4'd5, 4'd2, 4'd1, 3'd2);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_collect", 32'(state), 32'(3'd2));

    // Round 6 aborted by reset during UPDATE
    mv.p1_valid = 1'b1; mv.p1_move = 2'b11;
    mv.p2_valid = 1'b1; mv.p2_move = 2'b10;
    tick();
    mv.p1_valid = 1'b0; mv.p2_valid = 1'b0;
    tick();
    chk("r6_judge", 32'(state), 32'(3'd3));
    tick();
    chk("r6_update", 32'(state), 32'(3'd4));
    chk("r6_mr", 32'(matchresult), 32'(2'b10));
    reset = 1'b1;
    tick();
    chk("abort_mr", 32'(matchresult), 32'(2'b00));
    chk("abort_state", 32'(state), 32'(3'd0));
    chk("abort_round", 32'(round), 32'(4'd6));
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("abort_round_hold", 32'(round), 32'(4'd6));
    chk("abort_win_hold", 32'(win), 32'(4'd3));
    chk("abort_idle_hold", 32'(state), 32'(3'd0));

    // Match 2: five straight p1 wins
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("m2_clear", 32'(score_clr), 32'(1'b1));
    tick();
    chk("m2_collect", 32'(state), 32'(3'd2));
    chk("m2_cnt0", 32'(round), 32'(4'd0));
    for (int i = 0; i < 5; i++) begin
      run_round("w", wm1[i], 0, 2'b00, -1, wm2[i], 0, 2, 2'b10, wm1[i], wm2[i],
                4'(i + 1), 4'(i + 1), 4'd0, (i == 4) ? 3'd6 : 3'd2);
    end
    chk("w_go", 32'(game_over), 32'(1'b1));
    chk("w_winner", 32'(winner), 32'(2'b01));
    tick();
    chk("w_over_hold", 32'(state), 32'(3'd6));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_state", 32'(state), 32'(3'd1));
    chk("restart_clr", 32'(score_clr), 32'(1'b1));
    chk("restart_go", 32'(game_over), 32'(1'b0));
    chk("restart_winner", 32'(winner), 32'(2'b00));
    tick();
    chk("restart_collect", 32'(state), 32'(3'd2));
    chk("restart_clr_drop", 32'(score_clr), 32'(1'b0));
    chk("restart_win0", 32'(win), 32'(4'd0));
    chk("restart_round0", 32'(round), 32'(4'd0));

    // Match 3: nine draws reach the round limit
    for (int i = 0; i < 9; i++) begin
      dm = 2'(i % 3 + 1);
      run_round("d", dm, 0, 2'b00, -1, dm, 0, 2, 2'b01, dm, dm,
                4'(i + 1), 4'd0, 4'd0, (i == 8) ? 3'd6 : 3'd2);
    end
    chk("d_go", 32'(game_over), 32'(1'b1));
    chk("d_winner", 32'(winner), 32'(2'b11));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rps_match_ctrl.md
Name: rps_match_ctrl

Overview:
- Top-level sequencer for one rock-paper-scissors match.
- Clears the score datapath, collects one move from each of two players with a per-round timeout, and judges the round.
- Issues exactly one matchresult update per round to the score datapath (round/win/lose counters), then holds a display phase.
- Ends the match on a win target or a round limit and reports the winner.

Parameters:
- WIN_TARGET, 5, wins (either side) that end the match
- ROUNDS_MAX, 9, round count that ends the match
- TIMEOUT, 1000, cycles allowed in COLLECT before forfeit judging (>=2)
- SHOW_CYCLES, 4, cycles the judged round is held for display (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; returns the block to IDLE
- start  in  1  begin new match; honoured only in IDLE and OVER
- p1_move  in  2  01 rock, 10 paper, 11 scissors, 00 invalid
- p1_valid  in  1  p1_move offered
- p1_ready  out  1  p1 move not yet latched this round
- p2_move  in  2  same encoding as p1_move
- p2_valid  in  1  p2_move offered
- p2_ready  out  1  p2 move not yet latched this round
- round  in  4  round count from score datapath
- win  in  4  p1 win count from score datapath
- lose  in  4  p1 loss count from score datapath
- matchresult  out  2  to score datapath: 00 none, 01 draw, 10 p1 win, 11 p1 lose
- score_clr  out  1  one-cycle pulse; the score datapath's resetn is driven by ~score_clr
- p1_shown  out  2  latched p1 move, valid in SHOW/OVER
- p2_shown  out  2  latched p2 move, valid in SHOW/OVER
- state  out  3  current state encoding, for debug and display
- game_over  out  1  high in OVER
- winner  out  2  00 none, 01 p1, 10 p2, 11 tie; valid in OVER

Behaviour:
- All outputs registered; state encodings below are fixed.
- Reset (sync, high): state=IDLE, matchresult=00, score_clr=0, ready=0, shown=00, game_over=0, winner=00, timer=0, latches clear. Reset mid-round aborts the round; no matchresult is issued.
- IDLE(0): start -> CLEAR.
- CLEAR(1): score_clr=1 for exactly this one cycle; latches and timer cleared -> COLLECT.
- COLLECT(2):
  - pX_ready = ~pX_latched.
  - A move is latched on an edge where pX_valid & pX_ready & pX_move!=00. A move of 00 is ignored and the player stays ready.
  - After a move is latched, further valid pulses are ignored.
  - Both moves latched (same cycle or different cycles) -> JUDGE on the next edge.
  - Timer increments every cycle. At timer==TIMEOUT-1 with a move missing -> JUDGE with a forfeit.
- JUDGE(3):
  - Result is computed from p1's view: paper>rock, rock>scissors, scissors>paper; equal moves = draw (01).
  - Forfeit: only p1 missing -> 11; only p2 missing -> 10; both missing -> 01.
  - Missing moves show as 00.
- UPDATE(4): matchresult = judged result for exactly one cycle; 00 in every other state.
- SHOW(5):
  - Entered after UPDATE. The first SHOW cycle samples round/win/lose, which already reflect the update.
  - Sets end_flag = (win>=WIN_TARGET) | (lose>=WIN_TARGET) | (round>=ROUNDS_MAX).
  - Held SHOW_CYCLES cycles, then -> OVER if end_flag, else -> COLLECT with latches and timer cleared.
- OVER(6): game_over=1.
  - winner = 01 if win>lose, 10 if lose>win, 11 if equal.
  - start -> CLEAR (game_over and winner drop when CLEAR is entered).
- start in any state other than IDLE/OVER is ignored. ready=0 outside COLLECT.
- Latency: last move latched at edge N -> JUDGE at N+1, matchresult valid in cycle N+2, SHOW from N+3.

Test Plan:
- reset, start; p1=01 and p2=11 offered the same cycle -> exactly one cycle of matchresult=10; after update win=1, round=1; p1_shown=01, p2_shown=11.
- p1=10 at cycle 3 of COLLECT, p2=10 at cycle 7; extra p1 pulse with 11 at cycle 5 -> p1_ready low after cycle 3; extra pulse ignored; matchresult=01 once; p1_shown=10.
- p2 never offers, TIMEOUT=20 -> JUDGE exactly 20 cycles after entering COLLECT, matchresult=10; neither player offers -> 01; p1 offers 00 only -> treated as missing.
- p1 wins five straight rounds -> after the 5th SHOW: state=OVER, game_over=1, winner=01; start -> score_clr pulse of 1 cycle, counters 0, back in COLLECT.
- Nine draws with ROUNDS_MAX=9 -> OVER after round 9, winner=11; start while in COLLECT has no effect.
- reset asserted during UPDATE -> matchresult 00 on next edge, state IDLE, no further counter change.
